// File: rtl/lp_ser_link_ctrl.sv
// Startup sequencer and word-slot scheduler for the lp tree serializer.
// Brings the divider tree out of reset, locks a slot counter to div_clk_i, then issues one word per slot.
//
// state  | meaning
// IDLE   | link off, divider tree held in reset
// HOLD   | divider reset asserted for HOLD_CYCLES cycles
// SETTLE | divider released, waiting for the divided clocks to settle
// ALIGN  | waiting (bounded) for a div_clk_i rising edge to phase the slot counter
// RUN    | slot counter locked, one word loaded every WIDTH cycles

module lp_ser_link_ctrl #(
  parameter int unsigned      WIDTH         = 4,
  parameter int unsigned      SETTLE_CYCLES = 16,
  parameter logic [WIDTH-1:0] IDLE_WORD     = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             err_clr_i,
  input  logic             div_clk_i,
  output logic             div_rst_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] word_o,
  output logic             load_o,
  output logic             locked_o,
  output logic             err_o
);

  localparam int unsigned HOLD_CYCLES  = 4;
  localparam int unsigned ALIGN_CYCLES = 2 * WIDTH;
  localparam int unsigned TMR_MAX_A    = (SETTLE_CYCLES > ALIGN_CYCLES) ? SETTLE_CYCLES : ALIGN_CYCLES;
  localparam int unsigned TMR_MAX      = (TMR_MAX_A > HOLD_CYCLES) ? TMR_MAX_A : HOLD_CYCLES;
  localparam int unsigned TMR_W        = $clog2(TMR_MAX);
  localparam int unsigned SLOT_W       = $clog2(WIDTH);

  localparam logic [TMR_W-1:0]  TMR_HOLD   = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_SETTLE = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ALIGN  = TMR_W'(ALIGN_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SETTLE,
    ST_ALIGN,
    ST_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               stop_q, stop_d;
  logic               div_q1, div_q2;
  logic               div_edge;
  logic               phase_err;
  logic               err_set;
  logic               err_q;
  logic               div_rst_q, load_q, locked_q;
  logic [WIDTH-1:0]   word_q;
  logic               load_d;
  logic               xfer;

  assign div_edge = div_q1 & ~div_q2;

  // Once en_i drops in RUN, stop_q keeps ready_o low until the link is back in IDLE.
  assign ready_o = (state_q == ST_RUN) && (slot_q == SLOT_LAST) && en_i && !stop_q;
  assign xfer    = valid_i & ready_o;

  assign phase_err = (slot_q == SLOT_LAST) ? ~div_edge : div_edge;

  always_comb begin
    state_d = state_q;
    slot_d  = '0;
    tmr_d   = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
    stop_d  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          state_d = ST_HOLD;
          tmr_d   = TMR_HOLD;
        end
      end
      ST_HOLD: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          state_d = ST_SETTLE;
          tmr_d   = TMR_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          state_d = ST_ALIGN;
          tmr_d   = TMR_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (div_edge) begin
          state_d = ST_RUN;
        end else if (tmr_q == '0) begin
          state_d = ST_HOLD;
          tmr_d   = TMR_HOLD;
          err_set = 1'b1;
        end
      end
      ST_RUN: begin
        stop_d = stop_q | ~en_i;
        if (phase_err) begin
          state_d = ST_HOLD;
          tmr_d   = TMR_HOLD;
          err_set = 1'b1;
          stop_d  = 1'b0;
        end else if (stop_q && slot_q == '0) begin
          state_d = ST_IDLE;
          stop_d  = 1'b0;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  assign load_d = (state_d == ST_RUN) && (slot_d == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      slot_q    <= '0;
      tmr_q     <= '0;
      stop_q    <= 1'b0;
      div_q1    <= 1'b0;
      div_q2    <= 1'b0;
      err_q     <= 1'b0;
      div_rst_q <= 1'b0;
      load_q    <= 1'b0;
      locked_q  <= 1'b0;
      word_q    <= IDLE_WORD;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      tmr_q     <= tmr_d;
      stop_q    <= stop_d;
      div_q1    <= div_clk_i;
      div_q2    <= div_q1;
      err_q     <= err_set | (err_q & ~err_clr_i);
      div_rst_q <= (state_d == ST_SETTLE) || (state_d == ST_ALIGN) || (state_d == ST_RUN);
      load_q    <= load_d;
      locked_q  <= (state_d == ST_RUN);
      if (load_d) begin
        word_q <= xfer ? data_i : IDLE_WORD;
      end
    end
  end

  assign div_rst_o = div_rst_q;
  assign load_o    = load_q;
  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign word_o    = word_q;

endmodule

// File: tb/tb_lp_ser_link_ctrl.sv
// Bench for lp_ser_link_ctrl: behavioural divide-by-4 tree, cycle-indexed reference timeline
// and a per-window word scoreboard.
module tb_lp_ser_link_ctrl;
  localparam int W = 4;
  localparam int S = 16;
  localparam logic [W-1:0] IDLE_W = '0;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         en_i = 1'b0;
  logic         err_clr_i = 1'b0;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         div_clk_i;
  logic         div_rst_o, ready_o, load_o, locked_o, err_o;
  logic [W-1:0] word_o;

  logic s1, s2, d1;
  logic slip = 1'b0;
  logic stuck = 1'b0;

  int t = 0;
  int lk = 0;
  logic [W-1:0] exp_word = '0;
  int n_chk = 0;
  int n_pass = 0;

  lp_ser_link_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S), .IDLE_WORD(IDLE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .err_clr_i(err_clr_i),
    .div_clk_i(div_clk_i), .div_rst_o(div_rst_o), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .word_o(word_o), .load_o(load_o), .locked_o(locked_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Two cascaded divide-by-2 stages; d1 is the same clock delayed one cycle for slip injection.
  always_ff @(posedge clk_i or negedge div_rst_o) begin
    if (!div_rst_o) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d1 <= 1'b0;
    end else begin
      s1 <= ~s1;
      if (!s1) s2 <= ~s2;
      d1 <= s2;
    end
  end

  assign div_clk_i = stuck ? 1'b0 : (slip ? d1 : s2);

  task automatic step();
    @(posedge clk_i);
    #1;
    t++;
  endtask

  function automatic int ph();
    return (t - lk) % W;
  endfunction

  // Tree released at cycle r: first slow rise lands at r+1, is seen two flops later, repeats every W.
  function automatic int predict_lock(input int r);
    int d;
    d = r + 2;
    while (d < r + S) d += W;
    return d + 1;
  endfunction

  task automatic test_reset();
    rst_i = 1'b0;
    en_i = 1'b0;
    repeat (3) step();
    n_chk++; if (div_rst_o !== 1'b0) $display("FAIL reset div_rst_o got %b exp 0", div_rst_o); else n_pass++;
    n_chk++; if (ready_o !== 1'b0) $display("FAIL reset ready_o got %b exp 0", ready_o); else n_pass++;
    n_chk++; if (load_o !== 1'b0) $display("FAIL reset load_o got %b exp 0", load_o); else n_pass++;
    n_chk++; if (locked_o !== 1'b0) $display("FAIL reset locked_o got %b exp 0", locked_o); else n_pass++;
    n_chk++; if (err_o !== 1'b0) $display("FAIL reset err_o got %b exp 0", err_o); else n_pass++;
    n_chk++; if (word_o !== IDLE_W) $display("FAIL reset word_o got %h exp %h", word_o, IDLE_W); else n_pass++;
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_startup();
    logic e_rst, e_lock, e_load;
    t = 0;
    en_i = 1'b1;
    lk = predict_lock(5);
    repeat (lk + 8) begin
      step();
      e_rst  = (t >= 5);
      e_lock = (t >= lk);
      e_load = (t >= lk) && (ph() == 0);
      n_chk++; if (div_rst_o !== e_rst) $display("FAIL startup div_rst_o t=%0d got %b exp %b", t, div_rst_o, e_rst); else n_pass++;
      n_chk++; if (locked_o !== e_lock) $display("FAIL startup locked_o t=%0d got %b exp %b", t, locked_o, e_lock); else n_pass++;
      n_chk++; if (load_o !== e_load) $display("FAIL startup load_o t=%0d got %b exp %b", t, load_o, e_load); else n_pass++;
    end
    exp_word = IDLE_W;
  endtask

  task automatic test_streaming();
    logic [W-1:0] plan [5];
    logic         pv [5];
    logic [W-1:0] nxt;
    int k;
    plan = '{4'hA, 4'h5, 4'h3, 4'h0, 4'h9};
    pv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    nxt = IDLE_W;
    k = 0;
    for (int c = 0; c < 6 * W; c++) begin
      n_chk++; if (load_o !== (ph() == 0)) $display("FAIL stream load_o t=%0d got %b exp %b", t, load_o, ph() == 0); else n_pass++;
      n_chk++; if (ready_o !== (ph() == W - 1)) $display("FAIL stream ready_o t=%0d got %b exp %b", t, ready_o, ph() == W - 1); else n_pass++;
      n_chk++; if (word_o !== exp_word) $display("FAIL stream word_o t=%0d got %h exp %h", t, word_o, exp_word); else n_pass++;
      if (k < 5) begin
        valid_i = pv[k];
        data_i = pv[k] ? plan[k] : W'($urandom);
      end else begin
        valid_i = 1'b0;
      end
      if (ph() == W - 1) begin
        nxt = valid_i ? data_i : IDLE_W;
        k++;
      end
      step();
      if (ph() == 0) exp_word = nxt;
    end
    valid_i = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] nxt;
    nxt = IDLE_W;
    for (int c = 0; c < 30 * W; c++) begin
      n_chk++; if (load_o !== (ph() == 0)) $display("FAIL random load_o t=%0d got %b exp %b", t, load_o, ph() == 0); else n_pass++;
      n_chk++; if (ready_o !== (ph() == W - 1)) $display("FAIL random ready_o t=%0d got %b exp %b", t, ready_o, ph() == W - 1); else n_pass++;
      n_chk++; if (word_o !== exp_word) $display("FAIL random word_o t=%0d got %h exp %h", t, word_o, exp_word); else n_pass++;
      n_chk++; if (locked_o !== 1'b1) $display("FAIL random locked_o t=%0d got %b exp 1", t, locked_o); else n_pass++;
      valid_i = 1'($urandom);
      data_i = W'($urandom);
      if (ph() == W - 1) nxt = valid_i ? data_i : IDLE_W;
      step();
      if (ph() == 0) exp_word = nxt;
    end
    valid_i = 1'b0;
  endtask

  task automatic test_phase_slip();
    int t0;
    logic e_err, e_rst, e_lock;
    valid_i = 1'b0;
    while (ph() != 1) step();
    t0 = t;
    slip = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 3) slip = 1'b0;
      e_err  = (c >= 3);
      e_rst  = !(c >= 3 && c <= 6);
      e_lock = (c < 3);
      n_chk++; if (err_o !== e_err) $display("FAIL slip err_o c=%0d got %b exp %b", c, err_o, e_err); else n_pass++;
      n_chk++; if (div_rst_o !== e_rst) $display("FAIL slip div_rst_o c=%0d got %b exp %b", c, div_rst_o, e_rst); else n_pass++;
      n_chk++; if (locked_o !== e_lock) $display("FAIL slip locked_o c=%0d got %b exp %b", c, locked_o, e_lock); else n_pass++;
    end
    lk = predict_lock(t0 + 7);
    while (t < lk) step();
    n_chk++; if (locked_o !== 1'b1) $display("FAIL relock locked_o t=%0d got %b exp 1", t, locked_o); else n_pass++;
    n_chk++; if (load_o !== 1'b1) $display("FAIL relock load_o t=%0d got %b exp 1", t, load_o); else n_pass++;
    n_chk++; if (err_o !== 1'b1) $display("FAIL sticky err_o t=%0d got %b exp 1", t, err_o); else n_pass++;
    exp_word = IDLE_W;
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    n_chk++; if (err_o !== 1'b0) $display("FAIL clear err_o got %b exp 0", err_o); else n_pass++;
    t0 = t;
    slip = 1'b1;
    err_clr_i = 1'b1;
    step();
    step();
    n_chk++; if (err_o !== 1'b0) $display("FAIL coincident pre err_o got %b exp 0", err_o); else n_pass++;
    step();
    n_chk++; if (err_o !== 1'b1) $display("FAIL coincident set-wins err_o got %b exp 1", err_o); else n_pass++;
    n_chk++; if (locked_o !== 1'b0) $display("FAIL coincident locked_o got %b exp 0", locked_o); else n_pass++;
    slip = 1'b0;
    err_clr_i = 1'b0;
    lk = predict_lock(t0 + 7);
    while (t < lk) step();
    n_chk++; if (locked_o !== 1'b1) $display("FAIL relock2 locked_o t=%0d got %b exp 1", t, locked_o); else n_pass++;
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    n_chk++; if (err_o !== 1'b0) $display("FAIL clear2 err_o got %b exp 0", err_o); else n_pass++;
  endtask

  task automatic test_disable();
    logic e_load, e_on;
    while (ph() != 1) step();
    valid_i = 1'b1;
    data_i = 4'h7;
    en_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      e_load = (c == 3);
      e_on = (c <= 3);
      n_chk++; if (ready_o !== 1'b0) $display("FAIL disable ready_o c=%0d got %b exp 0", c, ready_o); else n_pass++;
      n_chk++; if (load_o !== e_load) $display("FAIL disable load_o c=%0d got %b exp %b", c, load_o, e_load); else n_pass++;
      n_chk++; if (locked_o !== e_on) $display("FAIL disable locked_o c=%0d got %b exp %b", c, locked_o, e_on); else n_pass++;
      n_chk++; if (div_rst_o !== e_on) $display("FAIL disable div_rst_o c=%0d got %b exp %b", c, div_rst_o, e_on); else n_pass++;
      n_chk++; if (word_o !== IDLE_W) $display("FAIL disable word_o c=%0d got %h exp %h", c, word_o, IDLE_W); else n_pass++;
    end
    valid_i = 1'b0;
  endtask

  task automatic test_async_reset();
    int t0;
    t0 = t;
    en_i = 1'b1;
    lk = predict_lock(t0 + 5);
    while (t < lk) step();
    n_chk++; if (locked_o !== 1'b1) $display("FAIL arst lock locked_o got %b exp 1", locked_o); else n_pass++;
    while (ph() != W - 1) step();
    valid_i = 1'b1;
    data_i = 4'hC;
    n_chk++; if (ready_o !== 1'b1) $display("FAIL arst ready_o got %b exp 1", ready_o); else n_pass++;
    step();
    valid_i = 1'b0;
    n_chk++; if (word_o !== 4'hC) $display("FAIL arst word_o got %h exp c", word_o); else n_pass++;
    while (ph() != W - 1) step();
    #3;
    rst_i = 1'b0;
    en_i = 1'b0;
    #1;
    n_chk++; if (div_rst_o !== 1'b0) $display("FAIL arst div_rst_o got %b exp 0", div_rst_o); else n_pass++;
    n_chk++; if (ready_o !== 1'b0) $display("FAIL arst ready_o got %b exp 0", ready_o); else n_pass++;
    n_chk++; if (load_o !== 1'b0) $display("FAIL arst load_o got %b exp 0", load_o); else n_pass++;
    n_chk++; if (locked_o !== 1'b0) $display("FAIL arst locked_o got %b exp 0", locked_o); else n_pass++;
    n_chk++; if (word_o !== IDLE_W) $display("FAIL arst word_o got %h exp %h", word_o, IDLE_W); else n_pass++;
    step();
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_timeout();
    int a;
    logic e_err, e_rst;
    stuck = 1'b1;
    t = 0;
    en_i = 1'b1;
    a = 5 + S;
    while (t < a + 12) begin
      step();
      e_err = (t >= a + 8);
      e_rst = (t >= 5 && t < a + 8) || (t >= a + 12);
      n_chk++; if (err_o !== e_err) $display("FAIL timeout err_o t=%0d got %b exp %b", t, err_o, e_err); else n_pass++;
      n_chk++; if (div_rst_o !== e_rst) $display("FAIL timeout div_rst_o t=%0d got %b exp %b", t, div_rst_o, e_rst); else n_pass++;
      if (t == a + 8) stuck = 1'b0;
    end
    lk = predict_lock(a + 12);
    while (t < lk) step();
    n_chk++; if (locked_o !== 1'b1) $display("FAIL timeout relock locked_o got %b exp 1", locked_o); else n_pass++;
    n_chk++; if (err_o !== 1'b1) $display("FAIL timeout sticky err_o got %b exp 1", err_o); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_startup();
    test_streaming();
    test_random();
    test_phase_slip();
    test_disable();
    test_async_reset();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
